mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between two requesters: the instruction-fetch port and the EX-stage data port (the data_sram_* traffic driven by EX).
- Arbitrates address phases with data priority and a starvation guard.
- Tracks outstanding transactions in order and routes each data_ok/rdata back to the requester that issued it.
- Drops responses to instruction fetches cancelled by a pipeline flush (exception / ertn).

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions (ID FIFO depth, ≥1).
- STARVE_LIMIT, 4, consecutive data wins while inst is waiting before inst gets forced priority.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request (held until inst_addr_ok)
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data returned
- inst_rdata  out  32  fetch read data
- inst_cancel  in  1  pulse: discard all fetch responses still owed
- data_req  in  1  data request (held until data_addr_ok)
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data response (load data or store done)
- data_rdata  out  32  load data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write flag
- mem_size  out  2  downstream size
- mem_wstrb  out  4  downstream strobes
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream response
- mem_rdata  in  32  downstream read data
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - Clears the ID FIFO (pointers, count, discard bits), the lock, the starvation counter and proto_err.
  - While reset is high, mem_req, both addr_ok and both data_ok outputs are 0.
  - Reset mid-transaction abandons outstanding IDs. The downstream memory must be reset in the same cycle.
- Selection (sel, combinational):
  - If locked, sel = locked_sel.
  - Else if both requesters request: inst when starve_cnt == STARVE_LIMIT, otherwise data.
  - Else sel = whichever requester is requesting.
- Forwarding: mem_req = (inst_req | data_req) & ~fifo_full.
  - sel = data: mem_* mirror data_*.
  - sel = inst: mem_wr = 0, mem_size = 2, mem_wstrb = 0, mem_wdata = 0, mem_addr = inst_addr.
- Lock:
  - If mem_req & ~mem_addr_ok, register locked = 1 and locked_sel = sel. This guarantees the request cannot switch mid-handshake.
  - Cleared on the cycle mem_addr_ok is seen with mem_req.
- Accept: accept = mem_req & mem_addr_ok.
  - The addr_ok of the selected requester = accept; the other requester's addr_ok = 0.
  - On accept, push {id = sel, discard = 0} into the FIFO.
  - fifo_full blocks acceptance even when a pop happens in the same cycle.
- Starvation counter:
  - On accept of data while inst_req = 1: increment, saturating at STARVE_LIMIT.
  - On accept of inst, or when inst_req = 0: reset to 0.
- Response:
  - On mem_data_ok, pop the FIFO head. No response is ever returned ahead of its own accept cycle.
  - inst_data_ok = mem_data_ok & head.id == inst & ~head.discard.
  - data_data_ok = mem_data_ok & head.id == data.
  - inst_rdata = data_rdata = mem_rdata (unregistered, zero latency).
  - Simultaneous push and pop: count unchanged, pointers both advance.
- Cancel:
  - inst_cancel sets discard on every valid inst entry, including an inst entry pushed in the same cycle.
  - Data entries are untouched.
  - inst_data_ok is never asserted for discarded entries.
  - A held, not yet accepted inst_req is the fetch stage's responsibility; the arbiter does not cancel it.
- Errors:
  - mem_data_ok with the FIFO empty sets proto_err (sticky until reset) and is otherwise ignored.
  - Pointers wrap modulo OUTSTANDING.

Test Plan:
- Simultaneous inst and data requests, both at 0x1c000000 area, mem_addr_ok = 1 every cycle → data accepted first, inst next cycle; responses return in order and assert data_data_ok then inst_data_ok with the matching mem_rdata.
- Store byte at 0x80000003 with wstrb 4'b1000 while mem_addr_ok is held low 3 cycles and inst_req rises in cycle 2 → mem_* stay on the store (lock); inst is accepted only after the store's addr_ok.
- Continuous data_req plus inst_req with STARVE_LIMIT = 4 → exactly 4 data accepts, then 1 inst accept, then the counter restarts.
- OUTSTANDING = 2, no mem_data_ok → third request sees mem_req = 0 and addr_ok = 0. On the first mem_data_ok the FIFO pops; the next cycle a new accept occurs.
- Two inst fetches outstanding, then an inst_cancel pulse, then both mem_data_ok → inst_data_ok stays 0 for both. A following data load's data_data_ok is delivered normally.
- mem_data_ok while the FIFO is empty → proto_err = 1 and stays 1. Reset asserted with 1 entry outstanding → proto_err, count and lock return to 0 and mem_req = 0 during reset.

Source files
------------

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Shares one SRAM-like port between fetch and data requesters,
//                with in-order response routing and fetch-cancel support.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  localparam int   PW       = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int   CW       = $clog2(OUTSTANDING + 1);
  localparam int   SW       = $clog2(STARVE_LIMIT + 1);
  localparam logic SEL_INST = 1'b1;

  logic                   locked_q, locked_d;
  logic                   locked_sel_q, locked_sel_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [OUTSTANDING-1:0] id_q, id_d;
  logic [OUTSTANDING-1:0] disc_q, disc_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   proto_err_q, proto_err_d;

  logic sel;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;
  logic head_id;
  logic head_disc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_full  = (count_q == CW'(OUTSTANDING));
    fifo_empty = (count_q == '0);

    if (locked_q)
      sel = locked_sel_q;
    else if (inst_req && data_req)
      sel = (starve_q == SW'(STARVE_LIMIT));
    else
      sel = inst_req;

    // Outputs are forced quiet while reset is held, independent of stale state.
    mem_req   = (inst_req | data_req) & ~fifo_full & ~reset;
    accept    = mem_req & mem_addr_ok;
    pop       = mem_data_ok & ~fifo_empty & ~reset;
    head_id   = id_q[rd_ptr_q];
    head_disc = disc_q[rd_ptr_q];

    if (sel == SEL_INST) begin
      mem_wr    = 1'b0;
      mem_size  = 2'd2;
      mem_wstrb = 4'b0000;
      mem_addr  = inst_addr;
      mem_wdata = 32'd0;
    end else begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end

    inst_addr_ok = accept & sel;
    data_addr_ok = accept & ~sel;
    inst_data_ok = pop & head_id & ~head_disc;
    data_data_ok = pop & ~head_id;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    proto_err    = proto_err_q;

    locked_d     = locked_q;
    locked_sel_d = locked_sel_q;
    if (mem_req) begin
      locked_d     = ~mem_addr_ok;
      locked_sel_d = sel;
    end

    starve_d = starve_q;
    if (accept && !sel && inst_req) begin
      if (starve_q != SW'(STARVE_LIMIT))
        starve_d = starve_q + 1'b1;
    end else if ((accept && sel) || !inst_req) begin
      starve_d = '0;
    end

    // Stale slots may also get their discard bit set; a push overwrites it.
    id_d   = id_q;
    disc_d = inst_cancel ? (disc_q | id_q) : disc_q;
    if (accept) begin
      id_d[wr_ptr_q]   = sel;
      disc_d[wr_ptr_q] = inst_cancel & sel;
    end

    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    if (accept && !pop)
      count_d = count_q + 1'b1;
    else if (!accept && pop)
      count_d = count_q - 1'b1;

    proto_err_d = proto_err_q | (mem_data_ok & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q     <= 1'b0;
      locked_sel_q <= 1'b0;
      starve_q     <= '0;
      id_q         <= '0;
      disc_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      locked_q     <= locked_d;
      locked_sel_q <= locked_sel_d;
      starve_q     <= starve_d;
      id_q         <= id_d;
      disc_q       <= disc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule
`default_nettype wire
